// File: rtl/exp_lut_arbiter_pkg.sv
// Shared types for the exp LUT arbiter: tag pipe entries and a round-robin pick helper.
package exp_arb_pkg;

    localparam int unsigned N_REQ_CFG   = 4;
    localparam int unsigned WIDTH_CFG   = 32;
    localparam int unsigned QINT_CFG    = 16;
    localparam int unsigned LUT_LAT_CFG = 1;
    localparam int unsigned TAG_W       = $clog2(N_REQ_CFG);

    typedef logic [TAG_W-1:0] tag_t;

    typedef struct packed {
        logic valid;
        tag_t tag;
    } tag_entry_t;

    typedef struct packed {
        logic found;
        tag_t idx;
    } pick_t;

    // First eligible index at or above ptr, wrapping around.
    function automatic pick_t rr_pick(input logic [N_REQ_CFG-1:0] elig, input tag_t ptr);
        pick_t       p;
        int unsigned cand;
        p = '0;
        for (int unsigned k = 0; k < N_REQ_CFG; k++) begin
            cand = (32'(ptr) + k) % N_REQ_CFG;
            if (!p.found && elig[TAG_W'(cand)]) begin
                p.found = 1'b1;
                p.idx   = TAG_W'(cand);
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/exp_lut_arbiter_if.sv
// Requester-side bus of the exp LUT arbiter: issue handshake plus per-requester responses.
interface exp_lut_arbiter_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 32
);
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*WIDTH-1:0] req_x;
    logic [N_REQ-1:0]       rsp_valid;
    logic [N_REQ-1:0]       rsp_ready;
    logic [N_REQ*WIDTH-1:0] rsp_data;

    modport master (
        output req_valid, req_x, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_x, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/exp_lut_arbiter_rr.sv
// Combinational round-robin arbiter: first eligible index scanning upward from ptr with wrap.
module rr_arbiter #(
    parameter  int unsigned N_REQ = 4,
    localparam int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] elig,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant_onehot,
    output logic [IDX_W-1:0] grant_idx,
    output logic             found
);

    int unsigned cand;

    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        found        = 1'b0;
        cand         = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = (32'(ptr) + k) % N_REQ;
            if (!found && elig[IDX_W'(cand)]) begin
                found     = 1'b1;
                grant_idx = IDX_W'(cand);
            end
        end
        if (found) grant_onehot[grant_idx] = 1'b1;
    end

endmodule

// File: rtl/exp_lut_arbiter.sv
// Shares one fixed-latency exp LUT among N_REQ requesters; tags each issue and routes
// the result back to a per-requester response register.
module exp_lut_arbiter
    import exp_arb_pkg::*;
#(
    parameter int unsigned N_REQ   = N_REQ_CFG,
    parameter int unsigned WIDTH   = WIDTH_CFG,
    parameter int unsigned QINT    = QINT_CFG,
    parameter int unsigned LUT_LAT = LUT_LAT_CFG
) (
    input  logic                   clk,
    input  logic                   rst_n,
    exp_lut_arbiter_if.slave       bus,
    output logic                   lut_valid_in,
    output logic [WIDTH-1:0]       lut_x,
    input  logic                   lut_valid_out,
    input  logic [WIDTH-1:0]       lut_exp,
    output logic                   err_orphan
);

    // Tag types come from the package, so the instance must match the configured requester count.
    if (N_REQ < 2 || N_REQ != N_REQ_CFG || LUT_LAT < 1 || QINT > WIDTH) begin : g_bad_cfg
        $error("exp_lut_arbiter: unsupported parameter set");
    end

    logic [N_REQ-1:0] busy;
    logic [N_REQ-1:0] elig;
    logic [N_REQ-1:0] grant_onehot;
    tag_t             grant_idx;
    logic             found;
    tag_t             rr_ptr;
    tag_entry_t       tag_pipe [LUT_LAT];
    tag_entry_t       head;
    logic             res_hit;
    logic [N_REQ-1:0] res_onehot;
    logic [N_REQ-1:0] rsp_hs;

    // Nothing is offered while reset is held, even if requesters are already valid.
    assign elig = rst_n ? (bus.req_valid & ~busy) : '0;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .elig         (elig),
        .ptr          (rr_ptr),
        .grant_onehot (grant_onehot),
        .grant_idx    (grant_idx),
        .found        (found)
    );

    assign bus.req_ready = grant_onehot;
    assign lut_valid_in  = found;
    assign lut_x         = bus.req_x[32'(grant_idx)*WIDTH +: WIDTH];

    assign head    = tag_pipe[LUT_LAT-1];
    assign res_hit = lut_valid_out && head.valid;
    assign rsp_hs  = bus.rsp_valid & bus.rsp_ready;

    always_comb begin
        res_onehot = '0;
        if (res_hit) res_onehot[head.tag] = 1'b1;
    end

    // Tag pipe mirrors the LUT latency; bubbles carry valid=0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < LUT_LAT; k++) tag_pipe[k] <= '0;
        end else begin
            tag_pipe[0] <= '{valid: found, tag: grant_idx};
            for (int unsigned k = 1; k < LUT_LAT; k++) tag_pipe[k] <= tag_pipe[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy       <= '0;
            rr_ptr     <= '0;
            err_orphan <= 1'b0;
        end else begin
            busy <= (busy & ~rsp_hs) | grant_onehot;
            if (found) rr_ptr <= (grant_idx == TAG_W'(N_REQ-1)) ? '0 : grant_idx + TAG_W'(1);
            if (lut_valid_out && !head.valid) err_orphan <= 1'b1;
        end
    end

    // Response registers; busy guarantees a slot is never written while still held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rsp_valid <= '0;
            bus.rsp_data  <= '0;
        end else begin
            bus.rsp_valid <= (bus.rsp_valid & ~rsp_hs) | res_onehot;
            if (res_hit) bus.rsp_data[32'(head.tag)*WIDTH +: WIDTH] <= lut_exp;
        end
    end

endmodule

// File: tb/tb_exp_lut_arbiter.sv
// Randomized scoreboard bench for exp_lut_arbiter with a stub LUT (exp = x + 0x100, one cycle).
module tb_exp_lut_arbiter;

    localparam int unsigned N   = 4;
    localparam int unsigned W   = 32;
    localparam int unsigned LAT = 1;

    typedef struct {
        logic [W-1:0] data;
        int           cyc;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         lut_valid_in, lut_valid_out, err_orphan;
    logic [W-1:0] lut_x, lut_exp;
    logic         stub_v, orphan_inj;
    logic [W-1:0] stub_d;

    logic [N-1:0] req_valid_d, rsp_ready_d, cont, acc_m, busy_m;
    logic [W-1:0] x_d    [N];
    logic [W-1:0] last_m [N];
    exp_t         exp_q  [N][$];
    int           ptr_m;
    logic         err_m;
    int           cyc;
    int           vectors, miscompares;

    int           g_c, j_c;
    logic [N-1:0] exp_rdy;
    logic         rv;

    exp_lut_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

    exp_lut_arbiter #(.N_REQ(N), .WIDTH(W), .QINT(16), .LUT_LAT(LAT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .lut_valid_in  (lut_valid_in),
        .lut_x         (lut_x),
        .lut_valid_out (lut_valid_out),
        .lut_exp       (lut_exp),
        .err_orphan    (err_orphan)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        bus.req_valid = req_valid_d;
        bus.rsp_ready = rsp_ready_d;
        for (int i = 0; i < N; i++) bus.req_x[i*W +: W] = x_d[i];
    end

    // Stub LUT with a one-cycle latency; orphan_inj forces a result strobe with nothing in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stub_v <= 1'b0;
            stub_d <= '0;
        end else begin
            stub_v <= lut_valid_in;
            stub_d <= lut_x + 32'h100;
        end
    end
    assign lut_valid_out = stub_v | orphan_inj;
    assign lut_exp       = stub_d;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference arbitration: scan requesters from the pointer, grant the first valid idle one.
    always @(negedge clk) begin
        if (rst_n) begin
            g_c = -1;
            for (int k = 0; k < N; k++) begin
                j_c = (ptr_m + k) % N;
                if (g_c < 0 && req_valid_d[j_c] && !busy_m[j_c]) g_c = j_c;
            end
            exp_rdy = '0;
            if (g_c >= 0) exp_rdy[g_c] = 1'b1;
            check("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
            check("lut_valid_in", 64'(lut_valid_in), 64'(g_c >= 0));
            if (g_c >= 0) begin
                check("lut_x", 64'(lut_x), 64'(x_d[g_c]));
                exp_q[g_c].push_back('{data: x_d[g_c] + 32'h100, cyc: cyc + LAT + 1});
                busy_m[g_c] = 1'b1;
                acc_m[g_c]  = 1'b1;
                ptr_m       = (g_c + 1) % N;
            end
            check("err_orphan", 64'(err_orphan), 64'(err_m));
            if (orphan_inj) err_m = 1'b1;
        end
    end

    // Response monitor: a result is due from its expected cycle until accepted.
    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            for (int i = 0; i < N; i++) begin
                rv = (exp_q[i].size() > 0) && (exp_q[i][0].cyc <= cyc);
                check($sformatf("rsp_valid[%0d]", i), 64'(bus.rsp_valid[i]), 64'(rv));
                check($sformatf("rsp_data[%0d]", i), 64'(bus.rsp_data[i*W +: W]),
                      64'(rv ? exp_q[i][0].data : last_m[i]));
                if (rv && rsp_ready_d[i]) begin
                    last_m[i] = exp_q[i][0].data;
                    void'(exp_q[i].pop_front());
                    busy_m[i] = 1'b0;
                end
            end
        end
    end

    // Advance one cycle; accepted requesters either reload (continuous) or drop valid.
    task automatic cycle();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc_m[i]) begin
                acc_m[i] = 1'b0;
                if (cont[i]) x_d[i] = $urandom;
                else         req_valid_d[i] = 1'b0;
            end
        end
    endtask

    task automatic do_reset(input bit wait_clk);
        rst_n = 1'b0;
        if (wait_clk) @(posedge clk);
        #1;
        check("rst_req_ready", 64'(bus.req_ready), 64'(0));
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        check("rst_rsp_data", 64'(bus.rsp_data), 64'(0));
        check("rst_lut_valid_in", 64'(lut_valid_in), 64'(0));
        check("rst_err_orphan", 64'(err_orphan), 64'(0));
        for (int i = 0; i < N; i++) begin
            exp_q[i].delete();
            last_m[i] = '0;
        end
        busy_m = '0;
        acc_m = '0;
        ptr_m = 0;
        err_m = 1'b0;
        orphan_inj = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic drain();
        req_valid_d = '0;
        cont = '0;
        rsp_ready_d = '1;
        repeat (8) cycle();
    endtask

    initial begin
        cyc = 0;
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        req_valid_d = '0;
        rsp_ready_d = '1;
        cont = '0;
        orphan_inj = 1'b0;
        for (int i = 0; i < N; i++) x_d[i] = '0;
        do_reset(1'b1);

        // Single request from requester 2.
        cycle();
        req_valid_d[2] = 1'b1;
        x_d[2] = 32'h0000_8000;
        cycle();
        repeat (5) cycle();

        // All four at once from a fresh pointer.
        do_reset(1'b1);
        for (int i = 0; i < N; i++) begin
            req_valid_d[i] = 1'b1;
            x_d[i] = 32'(i) * 32'h1000;
        end
        repeat (10) cycle();

        // Two continuous requesters.
        cont[0] = 1'b1;
        cont[1] = 1'b1;
        req_valid_d[1:0] = 2'b11;
        x_d[0] = $urandom;
        x_d[1] = $urandom;
        repeat (20) cycle();
        drain();

        // Backpressure on requester 1 while it keeps requesting.
        cont[0] = 1'b1;
        cont[1] = 1'b1;
        req_valid_d[1:0] = 2'b11;
        rsp_ready_d[1] = 1'b0;
        repeat (14) cycle();
        rsp_ready_d[1] = 1'b1;
        repeat (6) cycle();
        drain();

        // Random traffic with random backpressure.
        for (int n = 0; n < 300; n++) begin
            cycle();
            rsp_ready_d = N'($urandom);
            for (int i = 0; i < N; i++) begin
                if (!req_valid_d[i] && ($urandom_range(0, 1) == 1)) begin
                    req_valid_d[i] = 1'b1;
                    x_d[i] = $urandom;
                end
            end
        end
        drain();

        // Orphan strobe with an empty tag pipe.
        orphan_inj = 1'b1;
        cycle();
        orphan_inj = 1'b0;
        repeat (4) cycle();

        // Reset one cycle after a grant, with requests still pending.
        req_valid_d = '1;
        for (int i = 0; i < N; i++) x_d[i] = $urandom;
        cycle();
        do_reset(1'b0);
        repeat (8) cycle();
        drain();

        for (int i = 0; i < N; i++) check($sformatf("pending[%0d]", i), 64'(exp_q[i].size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/exp_lut_arbiter.md
Name: exp_lut_arbiter

Overview:
- Shares one fixed-point exp LUT pipeline among N_REQ requesters, e.g. the per-lane path-step units of the QMC GBM path generator.
- Round-robin arbitration; at most one request issued into the LUT per cycle.
- Tags each issued request, tracks it through the fixed LUT latency and routes the result to a per-requester response register with valid/ready.
- Sits between the path-step lanes and a single exp LUT instance; the LUT connects through the lut_* ports.

Parameters:
- N_REQ, 4, number of requesters (>=2).
- WIDTH, 32, data width of x and exp result.
- QINT, 16, integer bits of the Q format; pass-through only, no arithmetic in this block.
- LUT_LAT, 1, cycles from lut_valid_in to lut_valid_out (>=1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- req_valid  in  N_REQ  request valid per requester.
- req_ready  out  N_REQ  grant/accept per requester (one-hot or zero).
- req_x  in  N_REQ*WIDTH  packed operands; requester i uses bits [i*WIDTH +: WIDTH].
- rsp_valid  out  N_REQ  result valid per requester.
- rsp_ready  in  N_REQ  result accept per requester.
- rsp_data  out  N_REQ*WIDTH  packed results.
- lut_valid_in  out  1  issue strobe to the LUT.
- lut_x  out  WIDTH  operand to the LUT.
- lut_valid_out  in  1  LUT result strobe.
- lut_exp  in  WIDTH  LUT result.
- err_orphan  out  1  sticky: lut_valid_out arrived with no matching in-flight tag.

Behaviour:
- Reset is asynchronous and active-low (rst_n); clock is clk.
- Reset values: rsp_valid=0, rsp_data=0, busy=0, tag pipeline valids=0, rr_ptr=0, err_orphan=0. req_ready and lut_valid_in are 0 during reset.
- Eligibility: elig[i] = req_valid[i] & ~busy[i]. A requester has at most one outstanding operation.
- Arbitration (combinational):
  - Scan from rr_ptr upward with wrap-around; the first eligible index is grant g.
  - req_ready = onehot(g), or 0 if nothing is eligible.
  - lut_valid_in = |elig; lut_x = req_x[g].
- Clock edge with a grant:
  - busy[g] <= 1; rr_ptr <= (g+1) mod N_REQ.
  - Tag g with valid=1 enters a LUT_LAT-deep shift register.
- No grant: rr_ptr holds and a bubble (valid=0) enters the tag pipe.
- Result path: when lut_valid_out=1 and the tag pipe output is valid with tag t, then rsp_data[t] <= lut_exp and rsp_valid[t] <= 1 on the next edge.
- Response handshake: on rsp_valid[i] & rsp_ready[i], rsp_valid[i] <= 0 and busy[i] <= 0. rsp_data[i] holds its value until overwritten by a later result.
- A requester is re-eligible the cycle after its response handshake. Same-cycle response-accept and re-grant of that index is not possible.
- Latency: request accepted at cycle T -> lut_valid_out at T+LUT_LAT -> rsp_valid high from T+LUT_LAT+1.
- Throughput:
  - Aggregate: 1 issue per cycle.
  - Per requester: at best 1 per LUT_LAT+2 cycles (with rsp_ready tied high).
- Backpressure: rsp_ready low holds rsp_valid and rsp_data and keeps that requester ineligible. Other requesters are unaffected.
- No overwrite is possible, because busy blocks a second issue for the same requester.
- Orphan: if lut_valid_out=1 while the tag pipe output is invalid, set err_orphan=1 (sticky until reset) and drop the data.
- Missing result: if the tag pipe output is valid but lut_valid_out=0, the busy bit stays set. This is a LUT contract violation and is not recovered.
- Reset mid-operation: all in-flight tags and held responses are discarded immediately. The LUT is reset by the same rst_n.

Decomposition:
- Package exp_arb_pkg holds:
  - tag_t: logic [$clog2(N_REQ)-1:0].
  - The tag pipe entry struct {valid, tag}.
  - Function rr_pick(elig, ptr) returning {found, idx}.
- Sub-module rr_arbiter (N_REQ; inputs elig and ptr; outputs grant_onehot, grant_idx, found) is combinational and reused by other shared-resource arbiters.
- Top level holds busy, rr_ptr, the tag pipe and the response registers.

Test Plan:
- Bench stub LUT: lut_exp = lut_x + 0x100, delayed LUT_LAT=1.
- Single request: req 2 with x=0x00008000 at cycle 0 -> req_ready=0b0100 at cycle 0; rsp_valid[2] from cycle 2 with rsp_data[2]=0x00008100; other rsp_valid stay 0.
- All four request at cycle 0 (x=i*0x1000) -> grants 0,1,2,3 on cycles 0-3. rsp_valid[i] rises at cycle i+2 with data i*0x1000+0x100; rr_ptr=0 afterwards.
- Fairness: requesters 0 and 1 request continuously with rsp_ready=1 -> grants alternate 0,1,0,1; neither waits more than 1 cycle behind the other's issue.
- Backpressure: rsp_ready[1]=0 for 10 cycles after its result -> rsp_valid[1] and rsp_data[1] stable. No req_ready[1] while held; req_ready[1] returns the cycle after rsp_ready[1] goes high.
- Orphan: force lut_valid_out=1 with no issue -> err_orphan=1 next cycle and stays set; no rsp_valid changes.
- Reset mid-flight: assert rst_n=0 one cycle after a grant -> all outputs 0 immediately. After release, no stale rsp_valid, err_orphan=0, and the next request is granted normally.
